// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// instruction opcodes, ALU function codes and operand-select encodings.
// No ports (package).
package alu_op_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Instruction opcodes
  localparam logic [3:0] OPC_ADD  = 4'b0000;
  localparam logic [3:0] OPC_SUB  = 4'b0001;
  localparam logic [3:0] OPC_AND  = 4'b0010;
  localparam logic [3:0] OPC_OR   = 4'b0011;
  localparam logic [3:0] OPC_XOR  = 4'b0100;
  localparam logic [3:0] OPC_ADDI = 4'b1000;
  localparam logic [3:0] OPC_MUL  = 4'b1100;
  localparam logic [3:0] OPC_ACC  = 4'b1101;

  // ALU function codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_PASS  = 4'd5;
  localparam logic [3:0] ALU_MSTEP = 4'd6;

  // Operand mux select: A = register operand, B = immediate, C = accumulator
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_C = 2'b01;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the decode-side request (start, opcode) and the datapath control /
// status outputs of the sequencer.
//   master : decode stage / bench - drives start, opcode; observes controls
//   slave  : sequencer            - samples start, opcode; drives controls
//   CNT_W  : width of step_idx (iteration counter)
interface alu_op_sequencer_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [3:0]       opcode;
  logic [1:0]       sel_a;
  logic [3:0]       alu_op;
  logic             acc_write;
  logic             reg_write;
  logic [CNT_W-1:0] step_idx;
  logic             busy;
  logic             done;
  logic             illegal;

  modport master (
    output start, opcode,
    input  sel_a, alu_op, acc_write, reg_write, step_idx, busy, done, illegal
  );

  modport slave (
    input  start, opcode,
    output sel_a, alu_op, acc_write, reg_write, step_idx, busy, done, illegal
  );
endinterface

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_decode
// Purely combinational opcode decoder.
//   opcode  in  4 : latched instruction opcode
//   sel_a   out 2 : operand select for the execute cycle
//   alu_op  out 4 : ALU function for the execute cycle
//   is_mul  out 1 : opcode is the iterative multiply
//   is_acc  out 1 : result goes to the accumulator instead of the register file
//   illegal out 1 : opcode is not supported
// Multiply and illegal opcodes decode to SEL_A / ALU_PASS; the sequencer
// overrides the multiply controls in the states where they differ.
module alu_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [1:0] sel_a,
  output logic [3:0] alu_op,
  output logic       is_mul,
  output logic       is_acc,
  output logic       illegal
);

  always_comb begin
    sel_a   = SEL_A;
    alu_op  = ALU_PASS;
    is_mul  = 1'b0;
    is_acc  = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_ADD:  alu_op = ALU_ADD;
      OPC_SUB:  alu_op = ALU_SUB;
      OPC_AND:  alu_op = ALU_AND;
      OPC_OR:   alu_op = ALU_OR;
      OPC_XOR:  alu_op = ALU_XOR;
      OPC_ADDI: begin
        sel_a  = SEL_B;
        alu_op = ALU_ADD;
      end
      OPC_ACC: begin
        sel_a  = SEL_C;
        alu_op = ALU_ADD;
        is_acc = 1'b1;
      end
      OPC_MUL:  is_mul = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Multi-cycle control FSM stepping the execute datapath through EXEC,
// optional multiply iterations (ITER) and write-back (WB) for one
// instruction at a time.
//   clk  in : rising-edge clock
//   rst  in : asynchronous active-high reset, clears all state
//   bus     : alu_op_sequencer_if.slave (start/opcode in; sel_a, alu_op,
//             acc_write, reg_write, step_idx, busy, done, illegal out)
//   WIDTH   : datapath width, also the number of multiply iterations
//   CNT_W   : iteration counter width
// All outputs are decoded from registered state only, so there is no
// combinational path from start/opcode to any output.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [3:0]       opcode_reg;
  logic [CNT_W-1:0] count_reg;

  logic [1:0]       dec_sel;
  logic [3:0]       dec_op;
  logic             dec_mul;
  logic             dec_acc;
  logic             dec_illegal;

  logic             accepting;

  logic [1:0]       sel_a;
  logic [3:0]       alu_op;
  logic             acc_write;
  logic             reg_write;
  logic             busy;
  logic             done;
  logic             illegal;

  // A new opcode is taken from IDLE or from WB (back-to-back issue).
  assign accepting = (state == ST_IDLE) || (state == ST_WB);

  alu_op_decode u_decode (
    .opcode  (opcode_reg),
    .sel_a   (dec_sel),
    .alu_op  (dec_op),
    .is_mul  (dec_mul),
    .is_acc  (dec_acc),
    .illegal (dec_illegal)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latched opcode and multiply iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accepting && bus.start) begin
        opcode_reg <= bus.opcode;
      end
      if (state == ST_EXEC) begin
        count_reg <= '0;
      end else if (state == ST_ITER) begin
        // explicit wrap keeps non-power-of-two WIDTH correct
        count_reg <= (count_reg == LAST_STEP) ? '0 : count_reg + 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_EXEC;
      ST_EXEC: state_next = dec_mul ? ST_ITER : ST_WB;
      ST_ITER: if (count_reg == LAST_STEP) state_next = ST_WB;
      ST_WB:   state_next = bus.start ? ST_EXEC : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode (Moore)
  always_comb begin
    sel_a     = SEL_A;
    alu_op    = ALU_PASS;
    acc_write = 1'b0;
    reg_write = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (state)
      ST_EXEC: begin
        busy = 1'b1;
        if (dec_mul) begin
          // seed the accumulator with operand A before iterating
          acc_write = 1'b1;
        end else begin
          sel_a  = dec_sel;
          alu_op = dec_op;
        end
      end
      ST_ITER: begin
        busy      = 1'b1;
        sel_a     = SEL_C;
        alu_op    = ALU_MSTEP;
        acc_write = 1'b1;
      end
      ST_WB: begin
        busy = 1'b1;
        done = 1'b1;
        if (dec_illegal) begin
          illegal = 1'b1;
        end else if (dec_mul) begin
          // product sits in C; pass it through to the register file
          sel_a     = SEL_C;
          reg_write = 1'b1;
        end else begin
          sel_a  = dec_sel;
          alu_op = dec_op;
          if (dec_acc) acc_write = 1'b1;
          else         reg_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.sel_a     = sel_a;
  assign bus.alu_op    = alu_op;
  assign bus.acc_write = acc_write;
  assign bus.reg_write = reg_write;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.illegal   = illegal;
  assign bus.step_idx  = count_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Scoreboard bench: the driver pushes the expected instruction outcome for
// every accepted opcode; an independent monitor reconstructs each instruction
// from the DUT outputs and compares when Done pulses.
module tb_alu_op_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_ACC  = 4'b1101;

  localparam logic [3:0] A_ADD   = 4'd0;
  localparam logic [3:0] A_SUB   = 4'd1;
  localparam logic [3:0] A_AND   = 4'd2;
  localparam logic [3:0] A_OR    = 4'd3;
  localparam logic [3:0] A_XOR   = 4'd4;
  localparam logic [3:0] A_PASS  = 4'd5;
  localparam logic [3:0] A_MSTEP = 4'd6;

  localparam logic [1:0] S_A = 2'b00;
  localparam logic [1:0] S_B = 2'b10;
  localparam logic [1:0] S_C = 2'b01;

  typedef struct {
    logic [3:0] opc;
    bit         legal;
    logic [1:0] exec_sel;
    logic [3:0] exec_op;
    logic [1:0] wb_sel;
    logic [3:0] wb_op;
    int         lat;
    int         acc_cnt;
    int         reg_cnt;
    bit         wb_reg;
    bit         wb_acc;
    int         msteps;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  exp_t exp_q[$];

  alu_op_sequencer_if #(.CNT_W(CNT_W)) bus ();

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference: outcome of one instruction, from the opcode table.
  function automatic exp_t model(input logic [3:0] op);
    exp_t e;
    e.opc = op; e.legal = 1'b1; e.exec_sel = S_A; e.exec_op = A_PASS;
    e.lat = 2; e.acc_cnt = 0; e.reg_cnt = 1; e.wb_reg = 1'b1; e.wb_acc = 1'b0;
    e.msteps = 0;
    case (op)
      OP_ADD:  e.exec_op = A_ADD;
      OP_SUB:  e.exec_op = A_SUB;
      OP_AND:  e.exec_op = A_AND;
      OP_OR:   e.exec_op = A_OR;
      OP_XOR:  e.exec_op = A_XOR;
      OP_ADDI: begin e.exec_sel = S_B; e.exec_op = A_ADD; end
      OP_ACC: begin
        e.exec_sel = S_C; e.exec_op = A_ADD;
        e.acc_cnt = 1; e.reg_cnt = 0; e.wb_reg = 1'b0; e.wb_acc = 1'b1;
      end
      OP_MUL: begin
        e.lat = WIDTH + 2; e.acc_cnt = WIDTH + 1; e.msteps = WIDTH;
      end
      default: begin
        e.legal = 1'b0; e.reg_cnt = 0; e.wb_reg = 1'b0;
      end
    endcase
    if (op == OP_MUL) begin
      e.wb_sel = S_C; e.wb_op = A_PASS;
    end else begin
      e.wb_sel = e.exec_sel; e.wb_op = e.exec_op;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  task automatic step_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sel_a"},     int'(bus.sel_a), int'(S_A));
    check({tag, "_alu_op"},    int'(bus.alu_op), int'(A_PASS));
    check({tag, "_acc_write"}, int'(bus.acc_write), 0);
    check({tag, "_reg_write"}, int'(bus.reg_write), 0);
    check({tag, "_step_idx"},  int'(bus.step_idx), 0);
    check({tag, "_busy"},      int'(bus.busy), 0);
    check({tag, "_done"},      int'(bus.done), 0);
    check({tag, "_illegal"},   int'(bus.illegal), 0);
  endtask

  // Wait until the DUT can accept (optionally toggling start while it
  // cannot), then present one opcode for exactly one edge.
  task automatic issue(input logic [3:0] op, input bit noise);
    int waitc = 0;
    while (!(bus.busy == 1'b0 || bus.done == 1'b1)) begin
      bus.start  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.opcode = 4'($urandom);
      step_cycle();
      waitc++;
      if (waitc > 200) begin
        total++;
        $display("FAIL accept_timeout: busy=%0d done=%0d after %0d cycles", bus.busy, bus.done, waitc);
        bus.start = 1'b0;
        return;
      end
    end
    bus.start  = 1'b1;
    bus.opcode = op;
    exp_q.push_back(model(op));
    step_cycle();
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) step_cycle();
  endtask

  // Monitor: rebuild each instruction from EXEC up to its Done pulse.
  initial begin
    bit         active;
    bit         prev_busy;
    bit         prev_done;
    int         cyc, accn, regn, msn, serr, stray, ntx;
    logic [1:0] esel;
    logic [3:0] eop;
    exp_t       e;
    active = 0; prev_busy = 0; prev_done = 0; ntx = 0;
    cyc = 0; accn = 0; regn = 0; msn = 0; serr = 0; stray = 0;
    esel = '0; eop = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 0; prev_busy = 0; prev_done = 0;
        continue;
      end
      if (bus.busy && (!prev_busy || prev_done)) begin
        active = 1; cyc = 0; accn = 0; regn = 0; msn = 0; serr = 0; stray = 0;
        esel = bus.sel_a; eop = bus.alu_op;
      end
      if (active) begin
        cyc++;
        if (bus.acc_write) accn++;
        if (bus.reg_write) regn++;
        if (bus.alu_op == A_MSTEP) begin
          if (int'(bus.step_idx) != msn) serr++;
          msn++;
        end
        if (bus.illegal && !bus.done) stray++;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_done: done=1 with 0 outstanding, required none");
          end else begin
            e = exp_q.pop_front();
            check($sformatf("latency op=%b", e.opc), cyc, e.lat);
            check($sformatf("illegal op=%b", e.opc), int'(bus.illegal), e.legal ? 0 : 1);
            check($sformatf("reg_write_cycles op=%b", e.opc), regn, e.reg_cnt);
            check($sformatf("acc_write_cycles op=%b", e.opc), accn, e.acc_cnt);
            check($sformatf("wb_reg_write op=%b", e.opc), int'(bus.reg_write), int'(e.wb_reg));
            check($sformatf("wb_acc_write op=%b", e.opc), int'(bus.acc_write), int'(e.wb_acc));
            check($sformatf("mstep_cycles op=%b", e.opc), msn, e.msteps);
            check($sformatf("step_idx_seq_errors op=%b", e.opc), serr, 0);
            check($sformatf("stray_illegal op=%b", e.opc), stray, 0);
            if (e.legal) begin
              check($sformatf("exec_sel op=%b", e.opc), int'(esel), int'(e.exec_sel));
              check($sformatf("exec_alu_op op=%b", e.opc), int'(eop), int'(e.exec_op));
              check($sformatf("wb_sel op=%b", e.opc), int'(bus.sel_a), int'(e.wb_sel));
              check($sformatf("wb_alu_op op=%b", e.opc), int'(bus.alu_op), int'(e.wb_op));
            end
            ntx++;
            $display("txn %0d op=%b lat=%0d acc=%0d reg=%0d illegal=%0d", ntx, e.opc, cyc, accn, regn, bus.illegal);
          end
          active = 0;
        end
      end else if (bus.done) begin
        total++;
        $display("FAIL done_outside_instruction: done=1 busy=%0d, required done=0", bus.busy);
      end
      prev_busy = bus.busy;
      prev_done = bus.done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int waitc;
    bus.start  = 1'b0;
    bus.opcode = 4'b0000;
    rst = 1'b1;
    repeat (2) step_cycle();
    check_reset_outputs("por");
    rst = 1'b0;

    // directed: single op, back-to-back pair, multiply, illegal
    issue(OP_ADD, 1'b0);
    idle(3);
    issue(OP_ADDI, 1'b0);
    issue(OP_ACC, 1'b0);
    idle(2);
    issue(OP_MUL, 1'b0);
    issue(4'b0111, 1'b0);
    idle(2);
    // start noise while the multiply iterates
    issue(OP_MUL, 1'b0);
    issue(OP_SUB, 1'b1);
    idle(3);

    // abort a multiply at StepIdx=10
    issue(OP_MUL, 1'b0);
    waitc = 0;
    while (!(bus.alu_op == A_MSTEP && int'(bus.step_idx) == 10) && waitc < 100) begin
      step_cycle();
      waitc++;
    end
    check("abort_reached_step10", int'(bus.step_idx), 10);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("abort");
    step_cycle();
    step_cycle();
    check_reset_outputs("abort_hold");
    rst = 1'b0;
    issue(OP_XOR, 1'b0);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // drain
    bus.start = 1'b0;
    waitc = 0;
    while ((exp_q.size() != 0 || bus.busy) && waitc < 200) begin
      step_cycle();
      waitc++;
    end
    check("drain_outstanding", exp_q.size(), 0);
    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
